// File: rtl/alu_result_serializer.sv
// Buffers registered ALU results in a small FIFO and streams each one out
// least-significant byte first over a valid/ready byte interface.
module alu_result_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 2 * DATA_WIDTH,
  parameter int BYTE_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [OUT_WIDTH-1:0]          i_ALU_OUT,
  input  logic                          i_OUT_VALID,
  output logic [BYTE_WIDTH-1:0]         o_TX_DATA,
  output logic                          o_TX_VALID,
  input  logic                          i_TX_READY,
  output logic                          o_BUSY,
  output logic                          o_OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_COUNT
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int NBYTES = OUT_WIDTH / BYTE_WIDTH;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  generate
    if ((OUT_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
      $error("OUT_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state;
  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [OUT_WIDTH-1:0] shift;
  logic [IDX_W-1:0]     byte_idx;
  logic                 tx_valid;
  logic                 overflow;

  logic not_empty;
  logic last_byte;
  logic xfer;
  logic pop;
  logic push;

  // Pop happens when the shift register is (or is about to become) free.
  always_comb begin
    not_empty = (count != '0);
    last_byte = (byte_idx == IDX_W'(NBYTES - 1));
    xfer      = tx_valid && i_TX_READY;
    pop       = not_empty && ((state == IDLE) || (xfer && last_byte));
    push      = i_OUT_VALID && ((count < CNT_W'(FIFO_DEPTH)) || pop);
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_ALU_OUT;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      shift    <= '0;
      byte_idx <= '0;
      tx_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (i_OUT_VALID && !push) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (not_empty) begin
            shift    <= mem[rd_ptr];
            byte_idx <= '0;
            tx_valid <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (last_byte) begin
              // Chain straight into the next word so there is no bubble.
              if (not_empty) begin
                shift    <= mem[rd_ptr];
                byte_idx <= '0;
              end else begin
                tx_valid <= 1'b0;
                state    <= IDLE;
              end
            end else begin
              shift    <= shift >> BYTE_WIDTH;
              byte_idx <= byte_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign o_TX_DATA    = shift[BYTE_WIDTH-1:0];
  assign o_TX_VALID   = tx_valid;
  assign o_BUSY       = (state != IDLE) || not_empty;
  assign o_OVERFLOW   = overflow;
  assign o_FIFO_COUNT = count;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer: single word, backpressure,
// back-to-back words, overflow, full push/pop and asynchronous reset.
module tb_alu_result_serializer;

  logic        i_clk;
  logic        i_reset;
  logic [15:0] i_ALU_OUT;
  logic        i_OUT_VALID;
  logic [7:0]  o_TX_DATA;
  logic        o_TX_VALID;
  logic        i_TX_READY;
  logic        o_BUSY;
  logic        o_OVERFLOW;
  logic [2:0]  o_FIFO_COUNT;

  int total = 0;
  int bad   = 0;

  alu_result_serializer #(
    .DATA_WIDTH(8),
    .OUT_WIDTH (16),
    .BYTE_WIDTH(8),
    .FIFO_DEPTH(4)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_ALU_OUT   (i_ALU_OUT),
    .i_OUT_VALID (i_OUT_VALID),
    .o_TX_DATA   (o_TX_DATA),
    .o_TX_VALID  (o_TX_VALID),
    .i_TX_READY  (i_TX_READY),
    .o_BUSY      (o_BUSY),
    .o_OVERFLOW  (o_OVERFLOW),
    .o_FIFO_COUNT(o_FIFO_COUNT)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Expect a valid byte on the interface, then let the edge take it (ready assumed 1).
  task automatic expect_byte(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, o_TX_VALID, 1);
    check({tag, "_data"}, o_TX_DATA, exp);
    tick();
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, o_TX_VALID, 0);
    check({tag, "_busy"}, o_BUSY, 0);
    check({tag, "_count"}, o_FIFO_COUNT, 0);
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    tick();
    tick();
    i_reset = 1'b1;
    tick();
  endtask

  initial begin
    i_reset     = 1'b0;
    i_ALU_OUT   = '0;
    i_OUT_VALID = 1'b0;
    i_TX_READY  = 1'b0;
    #2;
    check("rst_data", o_TX_DATA, 0);
    check("rst_valid", o_TX_VALID, 0);
    check("rst_busy", o_BUSY, 0);
    check("rst_ovf", o_OVERFLOW, 0);
    check("rst_count", o_FIFO_COUNT, 0);
    do_reset();

    // 1: single word, two-cycle latency
    i_TX_READY  = 1'b1;
    i_ALU_OUT   = 16'hA55A;
    i_OUT_VALID = 1'b1;
    tick();
    i_OUT_VALID = 1'b0;
    i_ALU_OUT   = 16'hDEAD;
    check("t1_lat1_valid", o_TX_VALID, 0);
    check("t1_lat1_count", o_FIFO_COUNT, 1);
    tick();
    expect_byte("t1_b0", 8'h5A);
    expect_byte("t1_b1", 8'hA5);
    expect_idle("t1_end");

    // 2: backpressure holds the byte stable
    i_TX_READY  = 1'b0;
    i_ALU_OUT   = 16'h1234;
    i_OUT_VALID = 1'b1;
    tick();
    i_OUT_VALID = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_stall_valid", o_TX_VALID, 1);
      check("t2_stall_data", o_TX_DATA, 8'h34);
      tick();
    end
    i_TX_READY = 1'b1;
    expect_byte("t2_b0", 8'h34);
    expect_byte("t2_b1", 8'h12);
    expect_idle("t2_end");
    check("t2_ovf", o_OVERFLOW, 0);

    // 3: back-to-back words stream without bubbles
    i_ALU_OUT   = 16'h0102;
    i_OUT_VALID = 1'b1;
    tick();
    i_ALU_OUT = 16'h0304;
    tick();
    i_ALU_OUT = 16'h0506;
    expect_byte("t3_b0", 8'h02);
    i_OUT_VALID = 1'b0;
    expect_byte("t3_b1", 8'h01);
    expect_byte("t3_b2", 8'h04);
    expect_byte("t3_b3", 8'h03);
    expect_byte("t3_b4", 8'h06);
    expect_byte("t3_b5", 8'h05);
    expect_idle("t3_end");

    // 4: overflow with the sink stalled
    do_reset();
    i_TX_READY  = 1'b0;
    i_OUT_VALID = 1'b1;
    for (int w = 1; w <= 5; w++) begin
      i_ALU_OUT = 16'(w);
      tick();
    end
    check("t4_full_count", o_FIFO_COUNT, 4);
    check("t4_pre_ovf", o_OVERFLOW, 0);
    i_ALU_OUT = 16'h0006;
    tick();
    i_OUT_VALID = 1'b0;
    check("t4_count", o_FIFO_COUNT, 4);
    check("t4_ovf", o_OVERFLOW, 1);
    i_TX_READY = 1'b1;
    for (int w = 1; w <= 5; w++) begin
      expect_byte("t4_lo", 8'(w));
      expect_byte("t4_hi", 8'h00);
    end
    expect_idle("t4_end");
    check("t4_ovf_sticky", o_OVERFLOW, 1);

    // 5: full FIFO, push on the same edge as the last-byte pop
    do_reset();
    i_TX_READY  = 1'b0;
    i_OUT_VALID = 1'b1;
    for (int w = 1; w <= 5; w++) begin
      i_ALU_OUT = {2{8'(w * 17)}};
      tick();
    end
    i_OUT_VALID = 1'b0;
    check("t5_full", o_FIFO_COUNT, 4);
    i_TX_READY = 1'b1;
    expect_byte("t5_w1b0", 8'h11);
    i_ALU_OUT   = 16'h6666;
    i_OUT_VALID = 1'b1;
    expect_byte("t5_w1b1", 8'h11);
    i_OUT_VALID = 1'b0;
    check("t5_count", o_FIFO_COUNT, 4);
    check("t5_ovf", o_OVERFLOW, 0);
    for (int w = 2; w <= 6; w++) begin
      expect_byte("t5_lo", 8'(w * 17));
      expect_byte("t5_hi", 8'(w * 17));
    end
    expect_idle("t5_end");

    // 6: asynchronous reset mid-word
    i_TX_READY  = 1'b0;
    i_OUT_VALID = 1'b1;
    i_ALU_OUT   = 16'hBEEF;
    tick();
    i_ALU_OUT = 16'h0A0B;
    tick();
    i_ALU_OUT = 16'h0C0D;
    tick();
    i_OUT_VALID = 1'b0;
    check("t6_queued", o_FIFO_COUNT, 2);
    i_TX_READY = 1'b1;
    expect_byte("t6_b0", 8'hEF);
    i_reset = 1'b0;
    #1;
    check("t6_rst_valid", o_TX_VALID, 0);
    check("t6_rst_data", o_TX_DATA, 0);
    check("t6_rst_busy", o_BUSY, 0);
    check("t6_rst_count", o_FIFO_COUNT, 0);
    check("t6_rst_ovf", o_OVERFLOW, 0);
    tick();
    i_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_no_residue", o_TX_VALID, 0);
    end
    i_ALU_OUT   = 16'h00FF;
    i_OUT_VALID = 1'b1;
    tick();
    i_OUT_VALID = 1'b0;
    tick();
    expect_byte("t6_n0", 8'hFF);
    expect_byte("t6_n1", 8'h00);
    expect_idle("t6_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
